mux4_arbiter: RTL and testbench

MUX4_ARBITER -- requirements
Module: mux4_arbiter

---
 rtl/mux4_arbiter_pkg.sv | 39 +++
 rtl/mux4_1.sv | 12 +
 rtl/mux4_arbiter.sv | 117 +++++++++++
 tb/tb_mux4_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux4_arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
// Holds the FSM state enum, sizing constants and the round-robin search.
package mux4_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Nearest set bit after ptr wins; ptr itself is searched last.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// Existing 1-bit 4:1 mux; the arbiter steers its select.
module mux4_1
    import mux4_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] data_in,
    input  logic [SEL_W-1:0]   sel_in,
    output logic               y_out
);

    assign y_out = data_in[sel_in];

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter owning a shared 1-bit 4:1 mux, with a per-owner hold limit.
// State and hold counter are exported on dbg_* ports for checker binding.
module mux4_arbiter
    import mux4_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0] gnt_out,
    output logic [SEL_W-1:0]   sel_out,
    output logic               valid_out,
    output logic               y_out,
    output state_t             dbg_state_out,
    output logic [3:0]         dbg_hold_cnt_out
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [3:0]         r_hold;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [3:0]         w_hold_nxt;
    logic [NUM_REQ-1:0] w_cand;
    logic [SEL_W-1:0]   w_search_ptr;
    logic               w_owner_req;
    logic               w_release;
    pick_t              w_pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= SEL_W'(NUM_REQ - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // While owning, the owner is masked out so a hold expiry hands over to
    // any other requester before the owner is considered for a re-grant.
    always_comb begin
        w_owner_req  = req_in[r_sel];
        w_release    = !w_owner_req || (r_hold == HOLD_MAX);
        w_search_ptr = (r_state == GRANT) ? r_sel : r_ptr;
        w_cand       = (r_state == GRANT) ? (req_in & ~r_gnt) : req_in;
        w_pick       = rr_pick(w_cand, w_search_ptr);

        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;

        case (r_state)
            IDLE: begin
                w_gnt_nxt  = '0;
                w_hold_nxt = '0;
                if (w_pick.found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = onehot(w_pick.idx);
                    w_sel_nxt   = w_pick.idx;
                    w_ptr_nxt   = w_pick.idx;
                    w_hold_nxt  = 4'd1;
                end
            end
            GRANT: begin
                if (!w_release) begin
                    w_hold_nxt = r_hold + 4'd1;
                end else if (w_pick.found) begin
                    w_gnt_nxt  = onehot(w_pick.idx);
                    w_sel_nxt  = w_pick.idx;
                    w_ptr_nxt  = w_pick.idx;
                    w_hold_nxt = 4'd1;
                end else if (w_owner_req) begin
                    w_hold_nxt = 4'd1;
                end else begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    mux4_1 u_mux (
        .data_in (data_in),
        .sel_in  (r_sel),
        .y_out   (y_out)
    );

    assign gnt_out          = r_gnt;
    assign sel_out          = r_sel;
    assign valid_out        = |r_gnt;
    assign dbg_state_out    = r_state;
    assign dbg_hold_cnt_out = r_hold;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: reset, rotation, early drop, datapath,
// sole-requester expiry, mid-grant reset; a MAX_HOLD=1 copy shares the inputs.
module tb_mux4_arbiter;
  import mux4_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] data_in;

  logic [3:0] gnt_out;
  logic [1:0] sel_out;
  logic       valid_out;
  logic       y_out;
  state_t     dbg_state;
  logic [3:0] dbg_hold;

  logic [3:0] gnt1_out;
  logic [1:0] sel1_out;
  logic       valid1_out;
  logic       y1_out;
  state_t     dbg1_state;
  logic [3:0] dbg1_hold;

  int checks;
  int failures;

  mux4_arbiter #(.MAX_HOLD(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_in           (req_in),
    .data_in          (data_in),
    .gnt_out          (gnt_out),
    .sel_out          (sel_out),
    .valid_out        (valid_out),
    .y_out            (y_out),
    .dbg_state_out    (dbg_state),
    .dbg_hold_cnt_out (dbg_hold)
  );

  mux4_arbiter #(.MAX_HOLD(1)) dut_h1 (
    .clk              (clk),
    .rst              (rst),
    .req_in           (req_in),
    .data_in          (data_in),
    .gnt_out          (gnt1_out),
    .sel_out          (sel1_out),
    .valid_out        (valid1_out),
    .y_out            (y1_out),
    .dbg_state_out    (dbg1_state),
    .dbg_hold_cnt_out (dbg1_hold)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req_in   = 4'b1111;
    data_in  = 4'b0001;

    // reset held two cycles with everyone requesting
    step(2);
    check_eq("rst_gnt",   32'(gnt_out),   32'h0);
    check_eq("rst_sel",   32'(sel_out),   32'h0);
    check_eq("rst_valid", 32'(valid_out), 32'h0);
    check_eq("rst_hold",  32'(dbg_hold),  32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst_y_hi",  32'(y_out),     32'h1);
    data_in = 4'b1110;
    #1;
    check_eq("rst_y_lo",  32'(y_out),     32'h0);

    rst = 1'b0;
    step(1);
    check_eq("first_gnt",   32'(gnt_out),   32'h1);
    check_eq("first_sel",   32'(sel_out),   32'h0);
    check_eq("first_valid", 32'(valid_out), 32'h1);

    // rotation: 4 cycles per owner, no gaps; MAX_HOLD=1 copy rotates every cycle
    for (int g = 0; g < 5; g++) begin
      for (int c = 1; c <= 4; c++) begin
        check_eq("rot_gnt",  32'(gnt_out),  32'(oh(g % 4)));
        check_eq("rot_hold", 32'(dbg_hold), c);
        check_eq("h1_gnt",   32'(gnt1_out), 32'(oh((g * 4 + c - 1) % 4)));
        step(1);
      end
    end
    check_eq("rot_next_gnt", 32'(gnt_out), 32'h2);

    // owner 1 drops with nobody else: idle, select keeps last owner
    req_in = 4'b0000;
    step(1);
    check_eq("idle_gnt",   32'(gnt_out),   32'h0);
    check_eq("idle_valid", 32'(valid_out), 32'h0);
    check_eq("idle_sel",   32'(sel_out),   32'h1);
    check_eq("idle_state", 32'(dbg_state), 32'(IDLE));

    // early drop by requester 2, with datapath checks while it owns the mux
    req_in = 4'b0100;
    step(1);
    check_eq("ed_gnt",  32'(gnt_out),  32'h4);
    check_eq("ed_sel",  32'(sel_out),  32'h2);
    check_eq("ed_hold", 32'(dbg_hold), 32'h1);
    data_in = 4'b0100;
    #1;
    check_eq("dp_y_hi", 32'(y_out), 32'h1);
    data_in = 4'b0001;
    #1;
    check_eq("dp_y_lo", 32'(y_out), 32'h0);
    data_in = 4'b0101;
    #1;
    check_eq("dp_y_hi2", 32'(y_out), 32'h1);
    step(1);
    check_eq("ed_hold2", 32'(dbg_hold), 32'h2);
    req_in = 4'b0000;
    step(1);
    check_eq("ed_drop_gnt",   32'(gnt_out),   32'h0);
    check_eq("ed_drop_valid", 32'(valid_out), 32'h0);
    req_in = 4'b0001;
    #1;
    check_eq("ed_wait_gnt", 32'(gnt_out), 32'h0);
    step(1);
    check_eq("ed_new_gnt", 32'(gnt_out), 32'h1);
    check_eq("ed_new_sel", 32'(sel_out), 32'h0);

    // sole requester 1 held: continuous grant, hold reloads every 4 cycles
    req_in = 4'b0010;
    step(1);
    for (int i = 0; i < 10; i++) begin
      check_eq("sole_gnt",  32'(gnt_out),  32'h2);
      check_eq("sole_hold", 32'(dbg_hold), (i % 4) + 1);
      step(1);
    end

    // mid-grant reset while requester 3 owns
    req_in = 4'b1000;
    step(1);
    check_eq("mr_gnt", 32'(gnt_out), 32'h8);
    check_eq("mr_sel", 32'(sel_out), 32'h3);
    step(1);
    rst = 1'b1;
    step(1);
    check_eq("mr_rst_gnt",   32'(gnt_out),   32'h0);
    check_eq("mr_rst_valid", 32'(valid_out), 32'h0);
    check_eq("mr_rst_sel",   32'(sel_out),   32'h0);
    check_eq("mr_rst_hold",  32'(dbg_hold),  32'h0);
    data_in = 4'b0001;
    #1;
    check_eq("mr_rst_y", 32'(y_out), 32'h1);
    rst = 1'b0;
    step(1);
    check_eq("mr_after_gnt",  32'(gnt_out),   32'h8);
    check_eq("mr_after_sel",  32'(sel_out),   32'h3);
    check_eq("mr_after_hold", 32'(dbg_hold),  32'h1);
    check_eq("mr_after_vld",  32'(valid_out), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
